aer_spike_encoder: RTL and testbench

//  Downstream of the LIF neuron array. Captures rising edges on the level-type

---
 rtl/aer_spike_encoder.sv | 142 ++++++++++++++
 tb/tb_aer_spike_encoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/aer_spike_encoder.sv
`default_nettype none
// ============================================================================
// Module      : aer_spike_encoder
// Description : Converts axon rising edges into round-robin arbitrated AER
//               words {neuron, timestamp}, buffered in an FWFT FIFO.
//               Optional macro AER_TIMESTAMP_EN enables the timestamp path.
// Revision    : 1.0 - initial release
// ============================================================================
module aer_spike_encoder #(
  parameter int N_NEURONS  = 8,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_NEURONS-1:0]          axon_in,
  output logic                          aer_valid,
  input  logic                          aer_ready,
  output logic [ADDR_W-1:0]             aer_addr,
  output logic [TS_W-1:0]               aer_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [N_NEURONS-1:0] axon_prev;
  logic [N_NEURONS-1:0] pending;
  logic [N_NEURONS-1:0] rise;
  logic [N_NEURONS-1:0] req;
  logic [N_NEURONS-1:0] sel;
  logic [N_NEURONS-1:0] grant_onehot;
  logic [ADDR_W-1:0]    rr_ptr;
  logic [ADDR_W-1:0]    grant_idx;
  logic                 found;
  logic                 grant;
  logic                 push_ok;
  logic                 pop;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [ADDR_W-1:0]    addr_mem [FIFO_DEPTH];

  assign rise      = axon_in & ~axon_prev;
  assign req       = pending | rise;
  assign aer_valid = (fifo_count != '0);
  assign pop       = aer_valid & aer_ready;
  assign push_ok   = (fifo_count < CNT_W'(FIFO_DEPTH)) | pop;

  // Round robin: first pass covers indices above the pointer, second wraps to
  // the pointer itself, so the search order is rr+1 .. N-1, 0 .. rr.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    sel       = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (!found && req[i] && (ADDR_W'(i) > rr_ptr)) begin
        found     = 1'b1;
        grant_idx = ADDR_W'(i);
        sel[i]    = 1'b1;
      end
    end
    for (int i = 0; i < N_NEURONS; i++) begin
      if (!found && req[i] && (ADDR_W'(i) <= rr_ptr)) begin
        found     = 1'b1;
        grant_idx = ADDR_W'(i);
        sel[i]    = 1'b1;
      end
    end
  end

  assign grant        = found & push_ok;
  assign grant_onehot = grant ? sel : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      axon_prev  <= '0;
      pending    <= '0;
      rr_ptr     <= ADDR_W'(N_NEURONS - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      axon_prev <= axon_in;
      pending   <= req & ~grant_onehot;
      if (grant) begin
        rr_ptr <= grant_idx;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({grant, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // A rise on an already-pending neuron is merged away; that loss is sticky.
      if (|(rise & pending)) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      addr_mem[wr_ptr] <= grant_idx;
    end
  end

  assign aer_addr = aer_valid ? addr_mem[rd_ptr] : '0;

`ifdef AER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      ts_mem[wr_ptr] <= ts_cnt;
    end
  end

  assign aer_ts = aer_valid ? ts_mem[rd_ptr] : '0;
`else
  assign aer_ts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aer_spike_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_aer_spike_encoder
// Description : Directed self-checking bench for aer_spike_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aer_spike_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] axon_in;
  logic       aer_valid;
  logic       aer_ready;
  logic [2:0] aer_addr;
  logic [7:0] aer_ts;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       clr_ovf;

  int vectors    = 0;
  int miscompares = 0;

  aer_spike_encoder #(
    .N_NEURONS (8),
    .ADDR_W    (3),
    .FIFO_DEPTH(8),
    .TS_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .axon_in   (axon_in),
    .aer_valid (aer_valid),
    .aer_ready (aer_ready),
    .aer_addr  (aer_addr),
    .aer_ts    (aer_ts),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; axon_in = '0; aer_ready = 1'b0; clr_ovf = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; axon_in = 8'hA5; aer_ready = 1'b1; clr_ovf = 1'b0;
    tick();
    tick();
    vectors++; if (aer_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", aer_valid); end
    vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
    vectors++; if (aer_addr !== 3'd0) begin miscompares++; $display("FAIL reset_addr: got %0d expected 0", aer_addr); end
    vectors++; if (aer_ts !== 8'd0) begin miscompares++; $display("FAIL reset_ts: got %0d expected 0", aer_ts); end
  endtask

  task automatic test_single();
    do_reset();
    axon_in = 8'b0000_0100;
    tick();
    vectors++; if (aer_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %0b expected 1", aer_valid); end
    vectors++; if (aer_addr !== 3'd2) begin miscompares++; $display("FAIL single_addr: got %0d expected 2", aer_addr); end
    vectors++; if (aer_ts !== 8'd0) begin miscompares++; $display("FAIL single_ts: got %0d expected 0", aer_ts); end
    for (int i = 0; i < 9; i++) tick();
    vectors++; if (fifo_count !== 4'd1) begin miscompares++; $display("FAIL single_hold_count: got %0d expected 1", fifo_count); end
    axon_in = '0;
    aer_ready = 1'b1;
    tick();
    vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL single_pop_count: got %0d expected 0", fifo_count); end
    vectors++; if (aer_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop_valid: got %0b expected 0", aer_valid); end
  endtask

  task automatic test_burst();
    do_reset();
    aer_ready = 1'b1;
    axon_in = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      axon_in = '0;
      vectors++; if (aer_valid !== 1'b1 || aer_addr !== 3'(i)) begin
        miscompares++; $display("FAIL burst_addr[%0d]: got valid=%0b addr=%0d expected valid=1 addr=%0d", i, aer_valid, aer_addr, i);
      end
    end
    tick();
    vectors++; if (aer_valid !== 1'b0) begin miscompares++; $display("FAIL burst_drain: got %0b expected 0", aer_valid); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL burst_ovf: got %0b expected 0", overflow); end
    aer_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_seq [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      axon_in = 8'(1 << i);
      tick();
    end
    axon_in = '0;
    tick();
    axon_in = 8'h01;
    tick();
    axon_in = '0;
    tick();
    tick();
    vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL bp_count: got %0d expected 8", fifo_count); end
    vectors++; if (aer_addr !== 3'd0 || aer_valid !== 1'b1) begin miscompares++; $display("FAIL bp_head: got addr=%0d valid=%0b expected addr=0 valid=1", aer_addr, aer_valid); end
    aer_ready = 1'b1;
    tick();
    vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL bp_refill_count: got %0d expected 8", fifo_count); end
    for (int j = 0; j < 8; j++) begin
      vectors++; if (aer_valid !== 1'b1 || aer_addr !== exp_seq[j]) begin
        miscompares++; $display("FAIL bp_order[%0d]: got valid=%0b addr=%0d expected valid=1 addr=%0d", j, aer_valid, aer_addr, exp_seq[j]);
      end
      tick();
    end
    vectors++; if (aer_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %0b expected 0", aer_valid); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL bp_ovf: got %0b expected 0", overflow); end
    aer_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      axon_in = 8'(1 << i);
      tick();
    end
    axon_in = '0;  tick();
    axon_in = 8'h08; tick();
    axon_in = '0;  tick();
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_pending_only: got %0b expected 0", overflow); end
    axon_in = 8'h08; tick();
    axon_in = '0;  tick();
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
    vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL ovf_count: got %0d expected 8", fifo_count); end
    clr_ovf = 1'b1; tick();
    clr_ovf = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %0b expected 0", overflow); end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    for (int i = 0; i < 259; i++) tick();
    axon_in = 8'h20;
    tick();
    axon_in = '0;
    vectors++; if (aer_valid !== 1'b1 || aer_addr !== 3'd5) begin miscompares++; $display("FAIL ts_addr: got valid=%0b addr=%0d expected valid=1 addr=5", aer_valid, aer_addr); end
`ifdef AER_TIMESTAMP_EN
    vectors++; if (aer_ts !== 8'd3) begin miscompares++; $display("FAIL ts_wrap: got %0d expected 3", aer_ts); end
`else
    vectors++; if (aer_ts !== 8'd0) begin miscompares++; $display("FAIL ts_tied: got %0d expected 0", aer_ts); end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    do_reset();
    axon_in = 8'h3F;
    for (int i = 0; i < 4; i++) tick();
    vectors++; if (fifo_count !== 4'd4) begin miscompares++; $display("FAIL mid_count_before: got %0d expected 4", fifo_count); end
    rst = 1'b1;
    axon_in = '0;
    tick();
    vectors++; if (aer_valid !== 1'b0 || fifo_count !== 4'd0) begin miscompares++; $display("FAIL mid_reset: got valid=%0b count=%0d expected valid=0 count=0", aer_valid, fifo_count); end
    rst = 1'b0;
    aer_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (aer_valid) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL mid_stale: got event=%0b expected 0", seen); end
    aer_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_overflow();
    test_ts_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
